// File: rtl/regfile_32x64.sv
// 31 x WIDTH architectural registers plus hard-wired zero X31, two async read ports.
// Latency: writes commit at the sampling edge and are readable the next cycle; reads are combinational.
// Backpressure: none, a write can be accepted every cycle; multi-hot enables are dropped and flagged.
module regfile_32x64 #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREGS-1:0] wr_onehot,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_addr_a,
    input  logic [4:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             wr_ack,
    output logic             onehot_err
);

    localparam int ZR = NREGS - 1;

    logic [WIDTH-1:0] regs_q [ZR];
    logic [WIDTH-1:0] regs_d [ZR];
    logic             wr_ack_q;
    logic             wr_ack_d;
    logic             onehot_err_q;
    logic             onehot_err_d;

    logic [NREGS-1:0] onehot_minus1;
    logic             any_hot;
    logic             single_hot;
    logic             multi_hot;

    // x & (x-1) clears the lowest set bit, so zero means at most one bit was set.
    always_comb begin
        onehot_minus1 = wr_onehot - NREGS'(1);
        any_hot       = |wr_onehot;
        single_hot    = any_hot && ((wr_onehot & onehot_minus1) == '0);
        multi_hot     = any_hot && !single_hot;
    end

    always_comb begin
        for (int i = 0; i < ZR; i++) begin
            regs_d[i] = (single_hot && wr_onehot[i]) ? wr_data : regs_q[i];
        end
        wr_ack_d     = single_hot && !wr_onehot[ZR];
        onehot_err_d = onehot_err_q | multi_hot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ZR; i++) begin
                regs_q[i] <= '0;
            end
            wr_ack_q     <= 1'b0;
            onehot_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < ZR; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_ack_q     <= wr_ack_d;
            onehot_err_q <= onehot_err_d;
        end
    end

    // Addresses at or above the zero register have no storage and read as zero.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (int'(rd_addr_a) < ZR) begin
            rd_data_a = regs_q[rd_addr_a];
        end
        if (int'(rd_addr_b) < ZR) begin
            rd_data_b = regs_q[rd_addr_b];
        end
    end

    assign wr_ack     = wr_ack_q;
    assign onehot_err = onehot_err_q;

endmodule
